// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit with HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both run on
// unsigned magnitudes for WIDTH cycles. A one-cycle FIX state then applies the
// result signs and writes HI/LO. MTHI/MTLO write HI/LO directly in one cycle.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Multiply accumulator: upper half is the partial product, lower half the
  // multiplier as it shifts out.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // Multiplicand for MUL, divisor for DIV.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH:0]     rem_q, rem_d;
  // Dividend bits shift out of the top of this register and quotient bits
  // shift in at the bottom.
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               op_div_q, op_div_d;
  logic               dz_pend_q, dz_pend_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  // Operand conditioning and per-iteration datapath terms.
  logic               signed_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // Datapath helpers: magnitudes, one shift-add step, one restoring-divide step, sign fix-up.
  always_comb begin
    signed_op = (op == 3'd0) || (op == 3'd2);
    mag_a     = (signed_op && A[WIDTH-1]) ? (-A) : A;
    mag_b     = (signed_op && B[WIDTH-1]) ? (-B) : B;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift - {1'b0, opnd_q};

    prod_fix  = neg_res_q ? (-acc_q) : acc_q;
    quo_fix   = neg_res_q ? (-quo_q) : quo_q;
    rem_fix   = neg_rem_q ? (-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
  end

  // Next-state and register update logic for the FSM and HI/LO.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    a_orig_d   = a_orig_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    op_div_d   = op_div_q;
    dz_pend_d  = dz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              state_d    = S_MUL;
              cnt_d      = CNT_W'(WIDTH);
              acc_d      = {{WIDTH{1'b0}}, mag_b};
              opnd_d     = mag_a;
              neg_res_d  = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem_d  = 1'b0;
              op_div_d   = 1'b0;
              dz_pend_d  = 1'b0;
              div_zero_d = 1'b0;
            end
            3'd2, 3'd3: begin
              state_d    = S_DIV;
              cnt_d      = CNT_W'(WIDTH);
              rem_d      = '0;
              quo_d      = mag_a;
              opnd_d     = mag_b;
              a_orig_d   = A;
              neg_res_d  = signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem_d  = signed_op && A[WIDTH-1];
              op_div_d   = 1'b1;
              dz_pend_d  = (B == '0);
              div_zero_d = 1'b0;
            end
            3'd4: begin
              hi_d       = A;
              done_d     = 1'b1;
              div_zero_d = 1'b0;
            end
            3'd5: begin
              lo_d       = A;
              done_d     = 1'b1;
              div_zero_d = 1'b0;
            end
            default: begin
            end
          endcase
        end
      end

      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end

      S_DIV: begin
        rem_d = div_ge ? div_diff : div_shift;
        quo_d = {quo_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (op_div_q) begin
          // Divide by zero overrides the natural restoring result.
          if (dz_pend_q) begin
            lo_d       = '1;
            hi_d       = a_orig_q;
            div_zero_d = 1'b1;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, result and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      a_orig_q   <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      op_div_q   <= 1'b0;
      dz_pend_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      a_orig_q   <= a_orig_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      op_div_q   <= op_div_d;
      dz_pend_q  <= dz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: table-driven and random checks of alu_muldiv (WIDTH=32).
// Expected results are pushed to a scoreboard when an op is issued and are
// popped when done pulses.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[16];
  int unsigned n_cmp;
  int unsigned n_fail;
  logic [31:0] last_hi;
  logic [31:0] last_lo;
  logic        last_dz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] o, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz);
    exp_t e;
    e.hi  = eh;
    e.lo  = el;
    e.dz  = edz;
    e.lat = (o >= 3'd4) ? 1 : W + 2;
    sb.push_back(e);
    last_hi = eh;
    last_lo = el;
    last_dz = edz;
  endtask

  // Called at the negedge where done is expected; k = cycles since the start edge.
  task automatic compare_result(input int unsigned k);
    exp_t e;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: done still 0 after %0d cycles, required a pulse", k);
      if (sb.size() > 0) e = sb.pop_front();
    end else if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sb_empty: done=1 with no expected result queued, required no done");
    end else begin
      e = sb.pop_front();
      check("hi", 64'(hi), 64'(e.hi));
      check("lo", 64'(lo), 64'(e.lo));
      check("div_zero", 64'(div_zero), 64'(e.dz));
      check("latency", 64'(k), 64'(e.lat));
    end
  endtask

  // Waits for done from the negedge after the issue edge, then checks done falls.
  task automatic wait_and_check();
    int unsigned k;
    k = 1;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    compare_result(k);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'(0));
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz);
    push_exp(o, eh, el, edz);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(o < 3'd4));
    check("dz_clear_on_start", 64'(div_zero), 64'(0));
    wait_and_check();
  endtask

  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] mh, output logic [31:0] ml);
    logic signed [31:0] sa;
    logic signed [31:0] sb32;
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] sp;
    logic [63:0]        up;
    sa   = a;
    sb32 = b;
    sa64 = sa;
    sb64 = sb32;
    mh   = '0;
    ml   = '0;
    case (o)
      3'd0: begin
        sp = sa64 * sb64;
        mh = sp[63:32];
        ml = sp[31:0];
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        mh = up[63:32];
        ml = up[31:0];
      end
      3'd2: begin
        ml = sa / sb32;
        mh = sa % sb32;
      end
      default: begin
        ml = a / b;
        mh = a % b;
      end
    endcase
  endtask

  task automatic nop_test(input logic [2:0] o);
    start = 1'b1;
    op    = o;
    A     = 32'hDEAD_BEEF;
    B     = 32'h0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("nop_done", 64'(done), 64'(0));
      check("nop_busy", 64'(busy), 64'(0));
      @(negedge clk);
    end
    check("nop_hi", 64'(hi), 64'(last_hi));
    check("nop_lo", 64'(lo), 64'(last_lo));
    check("nop_dz", 64'(div_zero), 64'(last_dz));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] mh;
    logic [31:0] ml;
    logic [2:0]  ro;
    int unsigned k;

    n_cmp   = 0;
    n_fail  = 0;
    last_hi = '0;
    last_lo = '0;
    last_dz = 1'b0;
    rst     = 1'b1;
    start   = 1'b0;
    op      = 3'd0;
    A       = '0;
    B       = '0;

    tbl[0]  = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3]  = '{3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    tbl[4]  = '{3'd2, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    tbl[5]  = '{3'd3, 32'h0000_0009, 32'h0000_0003, 32'h0000_0000, 32'h0000_0003, 1'b0};
    tbl[6]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[7]  = '{3'd4, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'h8000_0000, 1'b0};
    tbl[8]  = '{3'd5, 32'h0000_55AA, 32'h0000_0000, 32'h0000_1234, 32'h0000_55AA, 1'b0};
    tbl[9]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    tbl[10] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
    tbl[11] = '{3'd1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0};
    tbl[12] = '{3'd0, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hEDCB_A988, 1'b0};
    tbl[13] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    tbl[14] = '{3'd3, 32'h0000_0010, 32'h0000_0000, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1};
    tbl[15] = '{3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz);
    end

    // Ops 6/7 are ignored, so the sticky div_zero from the last entry survives.
    nop_test(3'd6);
    nop_test(3'd7);

    // Random MUL/DIV against a behavioural model.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 3'($urandom_range(0, 3));
      if (i % 3 == 0) rb = rb & 32'h0000_00FF;
      if (rb == 32'h0) rb = 32'h1;
      if (ro == 3'd2 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'h3;
      model(ro, ra, rb, mh, ml);
      run_op(ro, ra, rb, mh, ml, 1'b0);
    end

    // start held high for a whole MULT: only the first and the done-cycle starts count.
    push_exp(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    start = 1'b1;
    op    = 3'd0;
    A     = 32'hFFFF_FFFD;
    B     = 32'h0000_0007;
    @(negedge clk);
    k = 1;
    while (!done && k < 100) begin
      op = 3'(k % 6);
      A  = $urandom;
      B  = (k % 4 == 0) ? 32'h0 : $urandom;
      @(negedge clk);
      k++;
    end
    compare_result(k);
    push_exp(3'd1, 32'h0000_0000, 32'h0000_002A, 1'b0);
    op = 3'd1;
    A  = 32'd6;
    B  = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("done_cycle_start_busy", 64'(busy), 64'(1));
    wait_and_check();

    // Async reset at cycle 10 of a MULT discards it and clears everything at once.
    start = 1'b1;
    op    = 3'd0;
    A     = 32'd5;
    B     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_hi", 64'(hi), 64'(0));
    check("midrst_lo", 64'(lo), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("postrst_busy", 64'(busy), 64'(0));
    check("postrst_done", 64'(done), 64'(0));
    run_op(3'd0, 32'd5, 32'd9, 32'd0, 32'd45, 1'b0);
    run_op(3'd2, 32'd45, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFB, 1'b0);

    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
